// File: rtl/lc3_mem_responder.sv
// LC-3 memory-side responder: main memory plus keyboard/display registers,
// answering MAR/MDR requests after a programmable number of wait states.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   mio_en, r_w, mar,     request (held until ready), 1 = write,
//   mdr_in                address and write data
//   mdr_out, ready        read data (held between reads), one-cycle completion
//   kbd_valid, kbd_char   keyboard character strobe and value
//   disp_valid, disp_char display character pending and value
//   disp_ack              display consumed the pending character
module lc3_mem_responder #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned MEM_WORDS   = 65024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mio_en,
    input  logic        r_w,
    input  logic [15:0] mar,
    input  logic [15:0] mdr_in,
    output logic [15:0] mdr_out,
    output logic        ready,
    input  logic        kbd_valid,
    input  logic [7:0]  kbd_char,
    output logic        disp_valid,
    output logic [7:0]  disp_char,
    input  logic        disp_ack
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned AW    = 16;
    localparam int unsigned DW    = 16;

    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);
    localparam logic [AW:0]      MEM_LIMIT = (AW + 1)'(MEM_WORDS);
    localparam logic [AW-1:0]    IO_BASE   = 16'hFE00;
    localparam logic [AW-1:0]    ADDR_KBSR = 16'hFE00;
    localparam logic [AW-1:0]    ADDR_KBDR = 16'hFE02;
    localparam logic [AW-1:0]    ADDR_DSR  = 16'hFE04;
    localparam logic [AW-1:0]    ADDR_DDR  = 16'hFE06;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    logic [DW-1:0] mem [0:MEM_WORDS-1];

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [AW-1:0]    addr_q;
    logic             rw_q;
    logic [DW-1:0]    wdata_q;
    logic             kbsr;
    logic [DW-1:0]    kbdr;

    logic [AW-1:0]    acc_addr;
    logic             acc_rw;
    logic [DW-1:0]    rd_data;
    logic             rd_hit;
    logic             wr_hit;
    logic             kbd_clear;
    logic             kbd_load;
    logic             ddr_load;

    // Next state, access decode and register side effects
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        acc_addr   = addr_q;
        acc_rw     = rw_q;
        rd_data    = '0;
        rd_hit     = 1'b0;
        wr_hit     = 1'b0;
        kbd_clear  = 1'b0;
        kbd_load   = 1'b0;
        ddr_load   = 1'b0;

        case (state)
            IDLE: begin
                if (mio_en) begin
                    cnt_next   = WAIT_LOAD;
                    state_next = (WAIT_LOAD == '0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_next = cnt - CNT_W'(1);
                if (cnt <= CNT_W'(1)) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // With zero wait states the read data is captured on the accepting edge,
        // so the live request must be decoded while still in IDLE.
        if (state == IDLE) begin
            acc_addr = mar;
            acc_rw   = r_w;
        end

        rd_hit = ({1'b0, acc_addr} < MEM_LIMIT) && (acc_addr < IO_BASE);
        wr_hit = ({1'b0, addr_q} < MEM_LIMIT) && (addr_q < IO_BASE);

        if (rd_hit) begin
            rd_data = mem[acc_addr];
        end else begin
            case (acc_addr)
                ADDR_KBSR: rd_data = {kbsr, 15'b0};
                ADDR_KBDR: rd_data = kbdr;
                ADDR_DSR:  rd_data = {~disp_valid, 15'b0};
                ADDR_DDR:  rd_data = {8'h00, disp_char};
                default:   rd_data = '0;
            endcase
        end

        kbd_clear = (state == RESP) && !rw_q && (addr_q == ADDR_KBDR);
        // A KBDR read frees the buffer this cycle, so a coincident strobe is kept.
        kbd_load  = kbd_valid && (!kbsr || kbd_clear);
        ddr_load  = (state == RESP) && rw_q && (addr_q == ADDR_DDR) &&
                    (!disp_valid || disp_ack);
    end

    // State, request latches and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            rw_q       <= 1'b0;
            wdata_q    <= '0;
            ready      <= 1'b0;
            mdr_out    <= '0;
            kbsr       <= 1'b0;
            kbdr       <= '0;
            disp_valid <= 1'b0;
            disp_char  <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (state == IDLE && mio_en) begin
                addr_q  <= mar;
                rw_q    <= r_w;
                wdata_q <= mdr_in;
            end
            ready <= (state_next == RESP);
            if (state_next == RESP && !acc_rw) begin
                mdr_out <= rd_data;
            end
            if (kbd_load) begin
                kbdr <= {8'h00, kbd_char};
                kbsr <= 1'b1;
            end else if (kbd_clear) begin
                kbsr <= 1'b0;
            end
            if (ddr_load) begin
                disp_char  <= wdata_q[7:0];
                disp_valid <= 1'b1;
            end else if (disp_ack) begin
                disp_valid <= 1'b0;
            end
        end
    end

    // Memory array; contents survive reset, and a reset edge aborts the commit
    always_ff @(posedge clk) begin
        if (rst_n && state == RESP && rw_q && wr_hit) begin
            mem[addr_q] <= wdata_q;
        end
    end

endmodule
